// File: rtl/pic_pkg.sv
// Shared constants and types for the PIC-style core sequencer.
// Phase index helpers keep strobe placement consistent across users.
package pic_pkg;

    localparam int PC_W_DEFAULT = 13;
    localparam int PH_FETCH = 0;
    localparam int PH_DATA = 1;

    typedef logic [PC_W_DEFAULT-1:0] pc_t;

    function automatic int ph_alu(input int phases);
        return phases - 2;
    endfunction

    function automatic int ph_wb(input int phases);
        return phases - 1;
    endfunction

endpackage

// File: rtl/pic_cycle_sequencer_if.sv
// Control/strobe bundle between the cycle sequencer and the core.
// master is the sequencer side, slave is the consuming core side.
interface pic_cycle_sequencer_if #(
    parameter int PHASES = 4,
    parameter int PC_W = 13
);
    localparam int PH_W = $clog2(PHASES);

    logic            stall;
    logic            jump;
    logic            call;
    logic            ret;
    logic            skip;
    logic [PC_W-1:0] target;
    logic [PH_W-1:0] phase;
    logic            inst_fetch;
    logic            data_fetch;
    logic            alu_exec;
    logic            write_back;
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        input  stall, jump, call, ret, skip, target,
        output phase, inst_fetch, data_fetch, alu_exec, write_back,
        output pc, valid, stack_ovf, stack_unf
    );

    modport slave (
        output stall, jump, call, ret, skip, target,
        input  phase, inst_fetch, data_fetch, alu_exec, write_back,
        input  pc, valid, stack_ovf, stack_unf
    );

endinterface

// File: rtl/pic_return_stack.sv
// Circular hardware return stack; overflow overwrites the oldest entry.
// Occupancy saturates so ovf/unf flag misuse without corrupting the pointer.
module pic_return_stack #(
    parameter int DEPTH = 8,
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         ovf,
    output logic         unf
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_dec;
    logic [PW:0]   occ;

    assign ptr_dec = ptr - 1'b1;
    assign top = mem[ptr_dec];

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
            occ <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (occ == FULL) ovf <= 1'b1;
            else occ <= occ + 1'b1;
        end else if (pop) begin
            ptr <= ptr_dec;
            if (occ == '0) unf <= 1'b1;
            else occ <= occ - 1'b1;
        end
    end

endmodule

// File: rtl/pic_cycle_sequencer.sv
// Instruction-cycle sequencer: phase counter, strobes, PC and skip logic.
// Strobes are clock enables qualified by stall, never gated clocks.
module pic_cycle_sequencer
    import pic_pkg::*;
#(
    parameter int PHASES = 4,
    parameter int PC_W = PC_W_DEFAULT,
    parameter int STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    pic_cycle_sequencer_if.master bus
);
    localparam int PH_W = $clog2(PHASES);
    localparam logic [PH_W-1:0] PH_F = PH_W'(PH_FETCH);
    localparam logic [PH_W-1:0] PH_D = PH_W'(PH_DATA);
    localparam logic [PH_W-1:0] PH_A = PH_W'(ph_alu(PHASES));
    localparam logic [PH_W-1:0] PH_L = PH_W'(ph_wb(PHASES));

    logic [PH_W-1:0] phase_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stk_top;
    logic            valid_q;
    logic            go;
    logic            take;
    logic            do_ret;
    logic            do_call;
    logic            do_jump;
    logic            do_skip;

    assign go = !bus.stall;
    assign pc_inc = pc_q + 1'b1;

    // Controls only count at the last phase of a live instruction.
    assign take = (phase_q == PH_L) && go && valid_q;
    assign do_ret = take && bus.ret;
    assign do_call = take && !bus.ret && bus.call;
    assign do_jump = take && !bus.ret && !bus.call && bus.jump;
    assign do_skip = take && !bus.ret && !bus.call && !bus.jump && bus.skip;

    assign bus.phase = phase_q;
    assign bus.pc = pc_q;
    assign bus.valid = valid_q;
    assign bus.inst_fetch = (phase_q == PH_F) && go;
    assign bus.data_fetch = (phase_q == PH_D) && go && valid_q;
    assign bus.alu_exec = (phase_q == PH_A) && go && valid_q;
    assign bus.write_back = (phase_q == PH_L) && go && valid_q;

    pic_return_stack #(
        .DEPTH(STACK_DEPTH),
        .W(PC_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (do_call),
        .pop      (do_ret),
        .push_data(pc_inc),
        .top      (stk_top),
        .ovf      (bus.stack_ovf),
        .unf      (bus.stack_unf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
            pc_q <= '0;
            valid_q <= 1'b1;
        end else if (go) begin
            phase_q <= (phase_q == PH_L) ? '0 : phase_q + 1'b1;
            if (phase_q == PH_L) begin
                valid_q <= !do_skip;
                unique case (1'b1)
                    do_ret:           pc_q <= stk_top;
                    do_call, do_jump: pc_q <= bus.target;
                    default:          pc_q <= pc_inc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pic_cycle_sequencer.sv
// Bench for pic_cycle_sequencer: per-cycle fetch scoreboard plus
// inline strobe, flag and reset checks.
module tb_pic_cycle_sequencer;

    logic clk;
    logic reset;
    int checks;
    int passed;
    logic sb_on;
    logic [13:0] sb[$];
    logic [13:0] sb_exp;

    pic_cycle_sequencer_if #(.PHASES(4), .PC_W(13)) bus ();

    pic_cycle_sequencer #(
        .PHASES(4),
        .PC_W(13),
        .STACK_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_on && bus.inst_fetch) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL fetch_unexpected: pc=%h valid=%b, none expected",
                         bus.pc, bus.valid);
            end else begin
                sb_exp = sb.pop_front();
                if ({bus.valid, bus.pc} !== sb_exp)
                    $display("FAIL fetch: got valid=%b pc=%h want valid=%b pc=%h",
                             bus.valid, bus.pc, sb_exp[13], sb_exp[12:0]);
                else
                    passed++;
            end
        end
    end

    task automatic clear_ctrl;
        bus.jump = 1'b0;
        bus.call = 1'b0;
        bus.ret = 1'b0;
        bus.skip = 1'b0;
        bus.target = '0;
    endtask

    // Runs one 4-clock instruction cycle from its first clock.
    task automatic do_cycle(input logic [12:0] epc, input logic ev,
                            input logic j, input logic c, input logic r,
                            input logic s, input logic [12:0] t);
        sb.push_back({ev, epc});
        bus.jump = j;
        bus.call = c;
        bus.ret = r;
        bus.skip = s;
        bus.target = t;
        repeat (4) @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic test_reset;
        logic [3:0] exp_s;
        logic [3:0] got_s;
        reset = 1'b0;
        bus.stall = 1'b0;
        clear_ctrl();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.phase, bus.pc, bus.valid, bus.stack_ovf, bus.stack_unf}
            !== {2'd0, 13'h000, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_state: got ph=%0d pc=%h v=%b ovf=%b unf=%b",
                     bus.phase, bus.pc, bus.valid, bus.stack_ovf, bus.stack_unf);
        else
            passed++;
        @(posedge clk);
        #1;
        sb.push_back({1'b1, 13'h000});
        sb_on = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_s = 4'b0001 << i;
            got_s = {bus.write_back, bus.alu_exec, bus.data_fetch, bus.inst_fetch};
            checks++;
            if (got_s !== exp_s || bus.phase !== 2'(i))
                $display("FAIL strobes_ph%0d: got ph=%0d s=%b want s=%b",
                         i, bus.phase, got_s, exp_s);
            else
                passed++;
            @(posedge clk);
            #1;
        end
        do_cycle(13'h001, 1'b1, 0, 0, 0, 0, 13'h000);
        do_cycle(13'h002, 1'b1, 0, 0, 0, 0, 13'h000);
    endtask

    task automatic test_jump;
        do_cycle(13'h003, 1'b1, 0, 0, 0, 0, 13'h000);
        do_cycle(13'h004, 1'b1, 1, 0, 0, 0, 13'h100);
        sb.push_back({1'b1, 13'h100});
        @(posedge clk);
        #1;
        bus.jump = 1'b1;
        bus.target = 13'h200;
        @(posedge clk);
        #1;
        clear_ctrl();
        repeat (2) @(posedge clk);
        #1;
        do_cycle(13'h101, 1'b1, 0, 0, 0, 0, 13'h000);
    endtask

    task automatic test_call_ret;
        do_cycle(13'h102, 1'b1, 1, 0, 0, 0, 13'h005);
        do_cycle(13'h005, 1'b1, 0, 1, 0, 0, 13'h020);
        do_cycle(13'h020, 1'b1, 0, 0, 1, 0, 13'h000);
        do_cycle(13'h006, 1'b1, 0, 0, 0, 0, 13'h000);
        checks++;
        if ({bus.stack_ovf, bus.stack_unf} !== 2'b00)
            $display("FAIL call_ret_flags: got ovf=%b unf=%b want 0 0",
                     bus.stack_ovf, bus.stack_unf);
        else
            passed++;
    endtask

    task automatic test_skip;
        do_cycle(13'h007, 1'b1, 1, 0, 0, 0, 13'h010);
        do_cycle(13'h010, 1'b1, 0, 0, 0, 1, 13'h000);
        sb.push_back({1'b0, 13'h011});
        bus.jump = 1'b1;
        bus.target = 13'h300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.data_fetch, bus.alu_exec, bus.write_back} !== 3'b000)
                $display("FAIL skip_strobes_ph%0d: got df=%b alu=%b wb=%b want 0",
                         i, bus.data_fetch, bus.alu_exec, bus.write_back);
            else
                passed++;
            @(posedge clk);
            #1;
        end
        clear_ctrl();
        do_cycle(13'h012, 1'b1, 0, 0, 0, 0, 13'h000);
    endtask

    task automatic test_stall;
        int pulses;
        sb.push_back({1'b1, 13'h013});
        repeat (2) @(posedge clk);
        #1;
        pulses = 0;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.alu_exec) pulses++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.phase !== 2'd2 || bus.pc !== 13'h013)
            $display("FAIL stall_hold: got ph=%0d pc=%h want ph=2 pc=013",
                     bus.phase, bus.pc);
        else
            passed++;
        bus.stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.alu_exec) pulses++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses !== 1)
            $display("FAIL stall_alu_once: got %0d pulses want 1", pulses);
        else
            passed++;
        do_cycle(13'h014, 1'b1, 0, 0, 0, 0, 13'h000);
    endtask

    task automatic test_stack_wrap;
        logic [12:0] ra [9];
        logic [12:0] cur;
        logic [12:0] tgt;
        ra[0] = 13'h016;
        for (int i = 1; i < 9; i++) ra[i] = 13'h100 + 13'((i - 1) * 16) + 13'h1;
        cur = 13'h015;
        for (int i = 0; i < 9; i++) begin
            tgt = 13'h100 + 13'(i * 16);
            do_cycle(cur, 1'b1, 0, 1, 0, 0, tgt);
            cur = tgt;
            if (i >= 7) begin
                checks++;
                if (bus.stack_ovf !== (i == 8))
                    $display("FAIL ovf_after_call%0d: got %b want %b",
                             i + 1, bus.stack_ovf, i == 8);
                else
                    passed++;
            end
        end
        for (int k = 0; k < 9; k++) begin
            do_cycle(cur, 1'b1, 0, 0, 1, 0, 13'h000);
            cur = (k < 8) ? ra[8 - k] : ra[8];
            if (k >= 7) begin
                checks++;
                if (bus.stack_unf !== (k == 8))
                    $display("FAIL unf_after_ret%0d: got %b want %b",
                             k + 1, bus.stack_unf, k == 8);
                else
                    passed++;
            end
        end
        do_cycle(cur, 1'b1, 0, 0, 0, 0, 13'h000);
        do_cycle(cur + 13'h1, 1'b1, 1, 0, 0, 0, 13'h1FFF);
        do_cycle(13'h1FFF, 1'b1, 0, 0, 0, 0, 13'h000);
        do_cycle(13'h000, 1'b1, 0, 0, 0, 0, 13'h000);
    endtask

    task automatic test_mid_reset;
        sb.push_back({1'b1, 13'h001});
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.phase !== 2'd2 || {bus.stack_ovf, bus.stack_unf} !== 2'b11)
            $display("FAIL pre_reset: got ph=%0d ovf=%b unf=%b want 2 1 1",
                     bus.phase, bus.stack_ovf, bus.stack_unf);
        else
            passed++;
        sb_on = 1'b0;
        reset = 1'b0;
        bus.jump = 1'b1;
        bus.target = 13'h0AA;
        @(posedge clk);
        #1;
        clear_ctrl();
        checks++;
        if ({bus.phase, bus.pc, bus.valid, bus.stack_ovf, bus.stack_unf}
            !== {2'd0, 13'h000, 1'b1, 1'b0, 1'b0})
            $display("FAIL mid_reset: got ph=%0d pc=%h v=%b ovf=%b unf=%b",
                     bus.phase, bus.pc, bus.valid, bus.stack_ovf, bus.stack_unf);
        else
            passed++;
        reset = 1'b1;
        sb_on = 1'b1;
        do_cycle(13'h000, 1'b1, 0, 0, 0, 0, 13'h000);
        do_cycle(13'h001, 1'b1, 0, 0, 0, 0, 13'h000);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        sb_on = 1'b0;
        test_reset();
        test_jump();
        test_call_ret();
        test_skip();
        test_stall();
        test_stack_wrap();
        test_mid_reset();
        checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pic_cycle_sequencer.md
Name: pic_cycle_sequencer

Overview:
- Parametrised instruction-cycle sequencer for the PIC-style core.
- Generates single-clock phase strobes for fetch, data read, ALU execute and write-back; these are clock enables, not gated clocks.
- Owns the program counter, a circular hardware return stack, and skip/flush handling.
- Sits between the core clock and Inst_Memory / Decoder / ALU / register file. It replaces the half_Freq divider chain and the strobe AND gates.

Parameters:
- PHASES, 4, clocks per instruction cycle (>=3).
- PC_W, 13, program counter width.
- STACK_DEPTH, 8, return stack entries (power of 2, >=2).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  freeze sequencer (e.g. slow memory).
- jump  in  1  load PC from target.
- call  in  1  push PC+1, load PC from target.
- ret  in  1  pop PC from stack.
- skip  in  1  nullify next instruction.
- target  in  PC_W  jump/call destination.
- phase  out  $clog2(PHASES)  current phase index.
- inst_fetch  out  1  strobe, phase 0.
- data_fetch  out  1  strobe, phase 1.
- alu_exec  out  1  strobe, phase PHASES-2.
- write_back  out  1  strobe, phase PHASES-1.
- pc  out  PC_W  address of the instruction in flight.
- valid  out  1  in-flight instruction is not nullified.
- stack_ovf  out  1  sticky, push onto a full stack.
- stack_unf  out  1  sticky, pop from an empty stack.

Behaviour:
- Reset (reset=0 sampled at a clk edge):
  - phase=0, pc=0, valid=1, stack pointer=0, occupancy=0, ovf=unf=0, stack contents don't-care.
  - Reset wins over every other input.
  - Mid-cycle reset aborts the instruction; no PC update and no stack change.
- Phase counter:
  - Advances 0..PHASES-1, then wraps to 0, on each clk with stall=0.
  - Holds while stall=1.
- Strobes:
  - Each strobe = (phase==its index) & ~stall.
  - An action therefore fires exactly once per cycle regardless of stall length.
  - For PHASES=3, alu_exec and data_fetch share phase 1.
  - inst_fetch is always generated.
  - data_fetch, alu_exec and write_back are additionally ANDed with valid.
- First strobe: inst_fetch is high in the first clock after reset is released, with pc=0.
- Control sampling:
  - jump/call/ret/skip/target are sampled only on the clk edge where phase==PHASES-1, stall=0 and valid=1.
  - They are ignored at all other times, including a nullified cycle.
- PC update at end of cycle, priority ret > call > jump > skip > increment:
  - ret: pc <= stack top; pointer decrements.
  - call: stack[ptr] <= pc+1; pointer increments; pc <= target.
  - jump: pc <= target.
  - skip: pc <= pc+1 and the next cycle has valid=0. The cycle after that has pc+2 and valid=1.
  - default: pc <= pc+1.
  - Lower-priority requests asserted alongside a higher one are dropped.
- Arithmetic: all PC arithmetic is modulo 2^PC_W; 0x1FFF+1 = 0x0000.
- Nullified cycle: pc increments normally at its end; valid returns to 1.
- Stack:
  - Circular; pointer wraps modulo STACK_DEPTH; occupancy saturates at 0 and STACK_DEPTH.
  - Push when occupancy==STACK_DEPTH overwrites the oldest entry and sets stack_ovf.
  - Pop when occupancy==0 still returns the entry at the wrapped pointer and sets stack_unf.
  - Flags clear only on reset.
- Stall: freezes phase, pc, valid, stack and flags. Control inputs are not sampled while stalled.

Decomposition:
- Shared package pic_pkg:
  - PC_W default.
  - Phase index constants PH_FETCH=0, PH_DATA=1.
  - Functions ph_alu(PHASES) and ph_wb(PHASES).
  - Typedef pc_t.
- One sub-module: pic_return_stack, holding the circular LIFO with push/pop/ovf/unf.
- Phase counter and PC logic stay in the top level.

Test Plan:
- PHASES=4, reset low 2 clocks, then release -> inst_fetch high on the 1st clock with pc=0; pc=0,1,2 for 4 clocks each; strobes appear on phases 0,1,2,3 in order.
- pc=0x004, jump=1, target=0x100 at phase 3 -> next cycle pc=0x100, valid=1. The same request held at phase 1 has no effect.
- call to 0x020 from pc=0x005, then ret at 0x020 -> pc=0x020, then 0x006; stack_ovf=stack_unf=0.
- 9 nested calls with STACK_DEPTH=8 -> stack_ovf=1 after the 9th. 9 rets return the 8 newest addresses, then wrap to the newest; stack_unf=1 after the 9th ret.
- skip at pc=0x010 -> cycle with pc=0x011 has valid=0; data_fetch/alu_exec/write_back stay low; jump asserted in that cycle is ignored. The next cycle has pc=0x012.
- stall high 3 clocks at phase 2 -> alu_exec pulses exactly once after release. Reset low at phase 2 -> next clock phase=0, pc=0, flags 0.
